// File: rtl/divclk_monitor_if.sv
// Bundle between the slow-clock monitor and its user: control inputs towards
// the monitor, step enable and measurement results back from it.
interface divclk_monitor_if #(
    parameter int CNT_W  = 16,
    parameter int EDGE_W = 32
);
    logic              clk_in;
    logic              halt;
    logic              clr;
    logic              step_en;
    logic [EDGE_W-1:0] edge_cnt;
    logic [CNT_W-1:0]  half_period;
    logic              period_vld;
    logic              stalled;

    // Driver of clk_in/halt/clr, consumer of the results
    modport master (
        output clk_in, halt, clr,
        input  step_en, edge_cnt, half_period, period_vld, stalled
    );

    // The monitor itself
    modport slave (
        input  clk_in, halt, clr,
        output step_en, edge_cnt, half_period, period_vld, stalled
    );
endinterface

// File: rtl/divclk_monitor.sv
// Divided-clock monitor: synchronises a slow square wave into the clk domain,
// emits a one-cycle step enable per accepted rising edge, counts rising edges,
// measures the last completed half-period and flags a stalled slow clock.
// Optional feature macro: DIVCLK_MON_GLITCH_FILTER_EN -- edges are accepted
// only once the synchronised level has been stable for two cycles.
module divclk_monitor #(
    parameter int CNT_W   = 16,
    parameter int EDGE_W  = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    divclk_monitor_if.slave  bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic              sync0_reg;
    logic              sync1_reg;
    logic              prev_reg;
    logic              rise;
    logic              fall;
    logic              acc_edge;

    logic              step_en_reg;
    logic [EDGE_W-1:0] edge_cnt_reg;
    logic [CNT_W-1:0]  phase_cnt_reg;
    logic [CNT_W-1:0]  half_period_reg;
    logic              period_vld_reg;
    logic              stalled_reg;
    logic [1:0]        state_reg;

    logic              phase_sat;
    logic              timeout_hit;
    logic [CNT_W-1:0]  phase_inc;

`ifdef DIVCLK_MON_GLITCH_FILTER_EN
    logic sync2_reg;

    // Two-FF synchroniser plus one filter stage; prev tracks the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_reg <= 1'b0;
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync0_reg <= bus.clk_in;
            sync1_reg <= sync0_reg;
            sync2_reg <= sync1_reg;
            if (sync1_reg == sync2_reg)
                prev_reg <= sync1_reg;
        end
    end

    // A level change counts only when it has persisted for two samples
    assign rise = sync1_reg & sync2_reg & ~prev_reg;
    assign fall = ~sync1_reg & ~sync2_reg & prev_reg;
`else
    // Two-FF synchroniser plus previous-sample register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_reg <= 1'b0;
            sync1_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync0_reg <= bus.clk_in;
            sync1_reg <= sync0_reg;
            prev_reg  <= sync1_reg;
        end
    end

    assign rise = sync1_reg & ~prev_reg;
    assign fall = ~sync1_reg & prev_reg;
`endif

    assign acc_edge    = rise | fall;
    assign phase_sat   = &phase_cnt_reg;
    assign phase_inc   = phase_cnt_reg + CNT_W'(1);
    assign timeout_hit = (phase_cnt_reg == TIMEOUT_LAST);

    // Step pulse and rising-edge counter; halt suppresses both, clr drops the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_en_reg  <= 1'b0;
            edge_cnt_reg <= '0;
        end else if (bus.clr) begin
            step_en_reg  <= 1'b0;
            edge_cnt_reg <= '0;
        end else begin
            step_en_reg <= rise & ~bus.halt;
            if (rise && !bus.halt)
                edge_cnt_reg <= edge_cnt_reg + EDGE_W'(1);
        end
    end

    // Saturating phase length counter, restarted by every accepted edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase_cnt_reg <= '0;
        else if (bus.clr || acc_edge)
            phase_cnt_reg <= '0;
        else if (!phase_sat)
            phase_cnt_reg <= phase_inc;
    end

    // Measurement FSM: arm on first edge, capture phases, detect stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            half_period_reg <= '0;
            period_vld_reg  <= 1'b0;
            stalled_reg     <= 1'b0;
        end else if (bus.clr) begin
            state_reg       <= ST_IDLE;
            half_period_reg <= '0;
            period_vld_reg  <= 1'b0;
            stalled_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (acc_edge) begin
                        state_reg <= ST_MEASURE;
                    end else if (timeout_hit) begin
                        state_reg   <= ST_STALLED;
                        stalled_reg <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (acc_edge) begin
                        half_period_reg <= phase_sat ? phase_cnt_reg : phase_inc;
                        period_vld_reg  <= 1'b1;
                    end else if (timeout_hit) begin
                        state_reg   <= ST_STALLED;
                        stalled_reg <= 1'b1;
                    end
                end
                ST_STALLED: begin
                    // The phase that ended in the stall is meaningless; keep old result
                    if (acc_edge) begin
                        state_reg   <= ST_MEASURE;
                        stalled_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.step_en     = step_en_reg;
    assign bus.edge_cnt    = edge_cnt_reg;
    assign bus.half_period = half_period_reg;
    assign bus.period_vld  = period_vld_reg;
    assign bus.stalled     = stalled_reg;

endmodule
